gate_sweep_checker: RTL and testbench

Exhaustive stimulus generator and response checker for the small combinational gate modules (2-/3-input OR/AND trees). It drives every input combination into the gate under test, waits a programmable settle time, and samples the gate output. Each sample is compared against the expected Boolean function, and the block reports a mismatch count and the first failing vector. It replaces hand-written `$display` sweeps with a reusable, synthesizable self-check stage wrapped around each gate.

---
 rtl/gate_sweep_checker.sv | 163 ++++++++++++++++
 tb/tb_gate_sweep_checker.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: exhaustive sweep generator and response checker for a
// small combinational gate. It drives every stim value from 0 to all-ones and
// holds each one for SETTLE cycles. On the following CHECK cycle it compares
// dut_s against the FUNC-reduction of stim. It counts mismatches and records
// the stim value of the first one.
//
// Parameters:
//   N_IN   - gate input count / stim width (1..8)
//   SETTLE - cycles each vector is held before sampling (1..15)
//   FUNC   - expected gate function: 0 OR-reduce, 1 AND-reduce, 2 XOR-reduce
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - synchronous active-low reset
//   start      - begin a sweep (honoured only in IDLE or DONE)
//   dut_s      - gate-under-test output
//   stim       - vector driven to the gate under test
//   busy       - sweep in progress
//   done       - sweep finished; held until next start or reset
//   pass       - valid with done; 1 iff err_count == 0
//   err_count  - number of mismatching vectors (max 2^N_IN, no saturation)
//   fail_valid - at least one mismatch recorded
//   first_fail - stim value of the first mismatch
module gate_sweep_checker #(
    parameter int unsigned N_IN   = 3,
    parameter int unsigned SETTLE = 1,
    parameter int unsigned FUNC   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              dut_s,
    output logic [N_IN-1:0]   stim,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_count,
    output logic              fail_valid,
    output logic [N_IN-1:0]   first_fail
);

    localparam int unsigned STIM_W = N_IN;
    localparam int unsigned ERR_W  = N_IN + 1;
    localparam int unsigned WAIT_W = 4;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt, wait_cnt_d;
    logic [STIM_W-1:0]   stim_d;
    logic                busy_d, done_d, pass_d, fail_valid_d;
    logic [ERR_W-1:0]    err_count_d;
    logic [STIM_W-1:0]   first_fail_d;
    logic                expected_c;
    logic                mismatch_c;

    // Reference function of the gate under test.
    always_comb begin
        expected_c = 1'b0;
        case (FUNC)
            0:       expected_c = |stim;
            1:       expected_c = &stim;
            2:       expected_c = ^stim;
            default: expected_c = |stim;
        endcase
    end

    assign mismatch_c = (dut_s != expected_c);

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wait_cnt   <= '0;
            stim       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            first_fail <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt   <= wait_cnt_d;
            stim       <= stim_d;
            busy       <= busy_d;
            done       <= done_d;
            pass       <= pass_d;
            err_count  <= err_count_d;
            fail_valid <= fail_valid_d;
            first_fail <= first_fail_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt;
        stim_d       = stim;
        busy_d       = busy;
        done_d       = done;
        pass_d       = pass;
        err_count_d  = err_count;
        fail_valid_d = fail_valid;
        first_fail_d = first_fail;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    stim_d       = '0;
                    err_count_d  = '0;
                    fail_valid_d = 1'b0;
                    first_fail_d = '0;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    wait_cnt_d   = '0;
                    busy_d       = 1'b1;
                    state_d      = WAIT;
                end
            end

            WAIT: begin
                wait_cnt_d = wait_cnt + WAIT_W'(1);
                if (wait_cnt == WAIT_LAST) begin
                    state_d = CHECK;
                end
            end

            CHECK: begin
                if (mismatch_c) begin
                    err_count_d = err_count + ERR_W'(1);
                    // Only the first mismatch of a sweep is recorded.
                    if (!fail_valid) begin
                        first_fail_d = stim;
                        fail_valid_d = 1'b1;
                    end
                end
                // Sweep ends at all-ones; stim never wraps.
                if (&stim) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    pass_d  = (err_count_d == '0);
                end else begin
                    stim_d     = stim + STIM_W'(1);
                    wait_cnt_d = '0;
                    state_d    = WAIT;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Scoreboard bench for gate_sweep_checker: stimulus pushes the expected sweep
// result (counters and completion cycle) into a per-instance queue, and a
// monitor per instance pops and compares whenever done rises.
module tb_gate_sweep_checker;

    typedef struct {
        int err;
        int ff;
        int fv;
        int ps;
        int done_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
    logic stuck0 = 1'b0;

    logic [2:0] stim0, stim1, stim2;
    logic       busy0, busy1, busy2;
    logic       done0, done1, done2;
    logic       pass0, pass1, pass2;
    logic [3:0] err0, err1, err2;
    logic       fv0, fv1, fv2;
    logic [2:0] ff0, ff1, ff2;
    logic       g0, g1, g2;

    int cyc = 0;
    int n_total = 0;
    int n_pass = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    logic pd0 = 1'b0, pd1 = 1'b0, pd2 = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Gates under test: a 3-input OR, optionally stuck at 0 on instance 0.
    assign g0 = stuck0 ? 1'b0 : |stim0;
    assign g1 = |stim1;
    assign g2 = |stim2;

    gate_sweep_checker #(.N_IN(3), .SETTLE(1), .FUNC(0)) u_or (
        .clk(clk), .rst_n(rst_n), .start(start0), .dut_s(g0),
        .stim(stim0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .fail_valid(fv0), .first_fail(ff0)
    );

    gate_sweep_checker #(.N_IN(3), .SETTLE(1), .FUNC(1)) u_and (
        .clk(clk), .rst_n(rst_n), .start(start1), .dut_s(g1),
        .stim(stim1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_valid(fv1), .first_fail(ff1)
    );

    gate_sweep_checker #(.N_IN(3), .SETTLE(3), .FUNC(1)) u_and_s3 (
        .clk(clk), .rst_n(rst_n), .start(start2), .dut_s(g2),
        .stim(stim2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .fail_valid(fv2), .first_fail(ff2)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic cmp_result(input string tag, input exp_t e, input int err,
                              input int ff, input int fv, input int ps);
        chk({tag, "_err_count"}, err, e.err);
        chk({tag, "_first_fail"}, ff, e.ff);
        chk({tag, "_fail_valid"}, fv, e.fv);
        chk({tag, "_pass"}, ps, e.ps);
        chk({tag, "_done_cycle"}, cyc, e.done_cyc);
    endtask

    // Monitors: compare on each rising edge of done.
    always @(negedge clk) begin
        if (done0 === 1'b1 && !pd0) begin
            if (q0.size() == 0) chk("or_unexpected_done", 1, 0);
            else cmp_result("or", q0.pop_front(), int'(err0), int'(ff0), int'(fv0), int'(pass0));
        end
        pd0 = (done0 === 1'b1);
    end

    always @(negedge clk) begin
        if (done1 === 1'b1 && !pd1) begin
            if (q1.size() == 0) chk("and_unexpected_done", 1, 0);
            else cmp_result("and", q1.pop_front(), int'(err1), int'(ff1), int'(fv1), int'(pass1));
        end
        pd1 = (done1 === 1'b1);
    end

    always @(negedge clk) begin
        if (done2 === 1'b1 && !pd2) begin
            if (q2.size() == 0) chk("and_s3_unexpected_done", 1, 0);
            else cmp_result("and_s3", q2.pop_front(), int'(err2), int'(ff2), int'(fv2), int'(pass2));
        end
        pd2 = (done2 === 1'b1);
    end

    // Called at a negedge: push expectation, then pulse start across one edge.
    task automatic issue(input int which, input int err, input int ff, input int fv,
                         input int ps, input int lat);
        exp_t e;
        e.err = err; e.ff = ff; e.fv = fv; e.ps = ps;
        e.done_cyc = cyc + 1 + lat;
        case (which)
            0: begin q0.push_back(e); start0 = 1'b1; end
            1: begin q1.push_back(e); start1 = 1'b1; end
            default: begin q2.push_back(e); start2 = 1'b1; end
        endcase
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    endtask

    task automatic wait_done(input int which, input string name);
        logic d;
        for (int i = 0; i < 200; i++) begin
            d = (which == 0) ? done0 : (which == 1) ? done1 : done2;
            if (d === 1'b1) begin
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic chk_idle0(input string tag);
        chk({tag, "_stim"}, int'(stim0), 0);
        chk({tag, "_busy"}, int'(busy0), 0);
        chk({tag, "_done"}, int'(done0), 0);
        chk({tag, "_pass"}, int'(pass0), 0);
        chk({tag, "_err_count"}, int'(err0), 0);
        chk({tag, "_fail_valid"}, int'(fv0), 0);
        chk({tag, "_first_fail"}, int'(ff0), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk_idle0("reset");
        @(negedge clk);

        // Correct OR gate: stim steps every 2 cycles, clean result at +16.
        issue(0, 0, 0, 0, 1, 16);
        for (int d = 0; d < 16; d++) begin
            chk("sweep_stim", int'(stim0), d / 2);
            chk("sweep_busy", int'(busy0), 1);
            @(negedge clk);
        end
        wait_done(0, "or_clean");

        // Output stuck at 0: vectors 001..111 mismatch, 000 does not.
        stuck0 = 1'b1;
        issue(0, 7, 1, 1, 0, 16);
        wait_done(0, "or_stuck");

        // Restart from a failing DONE with a corrected gate.
        stuck0 = 1'b0;
        issue(0, 0, 0, 0, 1, 16);
        chk("restart_err_cleared", int'(err0), 0);
        chk("restart_fv_cleared", int'(fv0), 0);
        chk("restart_ff_cleared", int'(ff0), 0);
        chk("restart_done_dropped", int'(done0), 0);
        chk("restart_busy", int'(busy0), 1);
        wait_done(0, "or_restart");

        // AND expectation against an OR gate, SETTLE=1 and SETTLE=3.
        issue(1, 6, 1, 1, 0, 16);
        wait_done(1, "and");
        issue(2, 6, 1, 1, 0, 32);
        wait_done(2, "and_s3");

        // start re-asserted mid-sweep must be ignored.
        issue(0, 0, 0, 0, 1, 16);
        repeat (4) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_done(0, "or_restart_ignored");

        // Reset mid-sweep with a stuck gate discards the sweep entirely.
        stuck0 = 1'b1;
        issue(0, 7, 1, 1, 0, 16);
        repeat (8) @(negedge clk);
        chk("pre_reset_fail_seen", int'(fv0), 1);
        rst_n = 1'b0;
        void'(q0.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        stuck0 = 1'b0;
        chk_idle0("midreset");
        repeat (3) @(negedge clk);
        chk("midreset_stays_idle", int'(busy0), 0);
        issue(0, 0, 0, 0, 1, 16);
        wait_done(0, "or_after_reset");

        repeat (2) @(negedge clk);
        chk("queue0_drained", q0.size(), 0);
        chk("queue1_drained", q1.size(), 0);
        chk("queue2_drained", q2.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
